// File: rtl/quad_comm_pkg.sv
// rtl/quad_comm_pkg.sv - shared opcodes, ack byte and RX state encoding for the command link
package quad_comm_pkg;

    localparam logic [7:0] REQ_BATT  = 8'h01;
    localparam logic [7:0] SET_PTCH  = 8'h02;
    localparam logic [7:0] SET_ROLL  = 8'h03;
    localparam logic [7:0] SET_YAW   = 8'h04;
    localparam logic [7:0] SET_THRST = 8'h05;
    localparam logic [7:0] CALIBRATE = 8'h06;
    localparam logic [7:0] EMER_LAND = 8'h07;
    localparam logic [7:0] MTRS_OFF  = 8'h08;

    localparam logic [7:0] POS_ACK   = 8'hA5;

    // Which byte of the 3-byte frame is expected next.
    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_HIGH = 2'd1,
        RX_LOW  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/cmd_resp_tx.sv
// rtl/cmd_resp_tx.sv - single-entry response path from the command FSM to the UART transmitter
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   snd_resp, resp  one-cycle send request and its response byte
//   tx_done         UART TX finished the current byte (pulse)
//   trmt, tx_data   one-cycle start pulse and byte to UART TX
//   resp_sent       set on tx_done, cleared by the next snd_resp
module cmd_resp_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       snd_resp,
    input  logic [7:0] resp,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    logic       busy;
    logic       pend_vld;
    logic [7:0] pend_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            pend_vld  <= 1'b0;
            pend_data <= 8'h00;
            trmt      <= 1'b0;
            tx_data   <= 8'h00;
            resp_sent <= 1'b0;
        end else begin
            trmt <= 1'b0;
            if (tx_done && busy) begin
                resp_sent <= 1'b1;
                // A request landing on the done cycle is the newest one, so it
                // takes the slot ahead of (and replaces) any pending byte.
                if (snd_resp) begin
                    tx_data  <= resp;
                    trmt     <= 1'b1;
                    pend_vld <= 1'b0;
                end else if (pend_vld) begin
                    tx_data  <= pend_data;
                    trmt     <= 1'b1;
                    pend_vld <= 1'b0;
                end else begin
                    busy <= 1'b0;
                end
            end else if (snd_resp) begin
                if (busy) begin
                    pend_data <= resp;
                    pend_vld  <= 1'b1;
                end else begin
                    tx_data <= resp;
                    trmt    <= 1'b1;
                    busy    <= 1'b1;
                end
            end
            // A fresh request means the previous completion no longer applies.
            if (snd_resp) begin
                resp_sent <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmd_frame_rcv.sv
// rtl/cmd_frame_rcv.sv - assembles 3-byte UART command frames and returns 1-byte responses
//
// Optional inter-byte timeout: define FRAME_TIMEOUT_EN (limit TIMEOUT_CYC clk cycles).
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   rx_rdy, rx_data, clr_rx_rdy     UART RX byte handshake
//   cmd_rdy, cmd, data, clr_cmd_rdy assembled frame to the command FSM
//   snd_resp, resp                  response request from the command FSM
//   trmt, tx_data, tx_done          UART TX handshake
//   resp_sent                       response byte has left the transmitter
module cmd_frame_rcv
    import quad_comm_pkg::*;
#(
    parameter logic [21:0] TIMEOUT_CYC = 22'd2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    input  logic        clr_cmd_rdy,
    input  logic        snd_resp,
    input  logic [7:0]  resp,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent
);

    if (TIMEOUT_CYC == 22'd0) begin : g_timeout_chk
        $error("TIMEOUT_CYC must be nonzero");
    end

    rx_state_t  state;
    logic [7:0] cmd_sh;
    logic [7:0] dhi_sh;
    logic [7:0] dlo_sh;
    logic       frame_done;
    logic       accept;
    logic       frame_start;
    logic       timeout;

    // The UART drops rx_rdy one cycle after our clear pulse; skipping that
    // cycle keeps a byte from being counted twice.
    assign accept = rx_rdy && !clr_rx_rdy;

`ifdef FRAME_TIMEOUT_EN
    logic [21:0] idle_cnt;

    assign timeout = (state != RX_IDLE) && (idle_cnt == TIMEOUT_CYC - 22'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= 22'd0;
        end else if ((state == RX_IDLE) || accept || timeout) begin
            idle_cnt <= 22'd0;
        end else begin
            idle_cnt <= idle_cnt + 22'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // A byte seen on the timeout cycle opens a new frame rather than
    // completing the abandoned one.
    assign frame_start = accept && ((state == RX_IDLE) || timeout);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= RX_IDLE;
            cmd_sh     <= 8'h00;
            dhi_sh     <= 8'h00;
            dlo_sh     <= 8'h00;
            frame_done <= 1'b0;
            cmd        <= 8'h00;
            data       <= 16'h0000;
            cmd_rdy    <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end else begin
            clr_rx_rdy <= 1'b0;
            frame_done <= 1'b0;

            if (frame_done) begin
                cmd  <= cmd_sh;
                data <= {dhi_sh, dlo_sh};
            end

            // Completion outranks a clear from the FSM; the first byte of a
            // new frame withdraws the stale one.
            if (frame_done) begin
                cmd_rdy <= 1'b1;
            end else if (frame_start || clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end

            if (accept) begin
                clr_rx_rdy <= 1'b1;
                if (frame_start) begin
                    cmd_sh <= rx_data;
                    state  <= RX_HIGH;
                end else if (state == RX_HIGH) begin
                    dhi_sh <= rx_data;
                    state  <= RX_LOW;
                end else begin
                    dlo_sh     <= rx_data;
                    frame_done <= 1'b1;
                    state      <= RX_IDLE;
                end
            end else if (timeout) begin
                state <= RX_IDLE;
            end
        end
    end

    cmd_resp_tx u_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .snd_resp  (snd_resp),
        .resp      (resp),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule
